// File: rtl/fp_issue_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// fp_issue_ctrl_pkg
//
// Shared types for the FP issue/writeback controller that sits on the
// requester side of fp_hub:
//   fp_operation_type    - decoded FP op, one bit per operation (one-hot)
//   fp_hub_in_type       - request bundle driven into the hub
//   fp_hub_out_type      - combinational hub response (result/flags/ready)
//   fp_issue_state_type  - controller state (IDLE / EXEC / RESP)
//   fp_issue_req_type    - instruction fields latched at accept
//   fp_issue_resp_type   - response fields returned to writeback
//   init_* constants     - all-zero reset values for the structs above
// ---------------------------------------------------------------------------
package fp_issue_ctrl_pkg;

    localparam int FFLAGS_W = 5;

    typedef struct packed {
        logic fmadd;
        logic fmsub;
        logic fnmadd;
        logic fnmsub;
        logic fadd;
        logic fsub;
        logic fmul;
        logic fdiv;
        logic fsqrt;
        logic fsgnj;
        logic fcmp;
        logic fmax;
        logic fclass;
        logic fmv_i2f;
        logic fmv_f2i;
        logic fcvt_i2f;
        logic fcvt_f2i;
        logic fcvt_f2f;
    } fp_operation_type;

    typedef struct packed {
        logic [63:0]      data1;
        logic [63:0]      data2;
        logic [63:0]      data3;
        fp_operation_type op;
        logic [1:0]       fmt;
        logic [2:0]       rm;
        logic             enable;
    } fp_hub_in_type;

    typedef struct packed {
        logic [63:0]         result;
        logic [FFLAGS_W-1:0] flags;
        logic                ready;
    } fp_hub_out_type;

    typedef enum logic [1:0] {
        FP_ISSUE_IDLE = 2'd0,
        FP_ISSUE_EXEC = 2'd1,
        FP_ISSUE_RESP = 2'd2
    } fp_issue_state_type;

    typedef struct packed {
        logic [63:0]      data1;
        logic [63:0]      data2;
        logic [63:0]      data3;
        fp_operation_type op;
        logic [1:0]       fmt;
        logic [2:0]       rm;
        logic [4:0]       rd;
        logic             wb_int;
    } fp_issue_req_type;

    typedef struct packed {
        logic [63:0]         result;
        logic [FFLAGS_W-1:0] flags;
        logic [4:0]          rd;
        logic                wb_int;
        logic                timeout;
    } fp_issue_resp_type;

    localparam fp_issue_req_type  init_fp_issue_req  = '0;
    localparam fp_issue_resp_type init_fp_issue_resp = '0;
    localparam fp_hub_in_type     init_fp_hub_in     = '0;

endpackage

// File: rtl/fp_issue_ctrl_fflags.sv
// ---------------------------------------------------------------------------
// fp_issue_ctrl_fflags
//
// Architectural fflags accumulator. Each bit is sticky until a CSR clear.
// A clear and an accumulate in the same cycle leave the newly accumulated
// flags set, so an exception raised by the retiring op is never lost.
//
// Ports:
//   clk       core clock
//   rst_n     synchronous active-low reset
//   clr_i     CSR write clears the accumulator
//   acc_en_i  a response is being retired this cycle
//   flags_i   flags of the retiring response
//   fflags_o  accumulated flags
// ---------------------------------------------------------------------------
module fp_issue_ctrl_fflags
    import fp_issue_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr_i,
    input  logic                acc_en_i,
    input  logic [FFLAGS_W-1:0] flags_i,
    output logic [FFLAGS_W-1:0] fflags_o
);

    logic [FFLAGS_W-1:0] fflags_reg;
    logic [FFLAGS_W-1:0] fflags_next;

    generate
        for (genvar gi = 0; gi < FFLAGS_W; gi++) begin : g_bit
            assign fflags_next[gi] = (fflags_reg[gi] & ~clr_i) | (acc_en_i & flags_i[gi]);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fflags_reg <= '0;
        end else begin
            fflags_reg <= fflags_next;
        end
    end

    assign fflags_o = fflags_reg;

endmodule

// File: rtl/fp_issue_ctrl.sv
// ---------------------------------------------------------------------------
// fp_issue_ctrl
//
// Issue/writeback controller in front of fp_hub. Accepts one FP instruction
// at a time, holds its operands on the hub while the unit works, captures
// the hub's combinational result on the first ready cycle and presents it to
// writeback with a valid/ready handshake. A watchdog aborts an op that never
// completes; a flush kills the op in flight and pulses the hub clear for two
// cycles.
//
// Parameters:
//   TIMEOUT_CYC  EXEC cycles allowed before a forced abort
//   CNT_W        watchdog counter width (2**CNT_W > TIMEOUT_CYC)
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   req_valid_i / req_ready_o  instruction request handshake
//   req_data1_i..req_data3_i   source operands
//   req_op_i, req_fmt_i, req_rm_i, req_rd_i, req_wb_int_i  instruction fields
//   fp_hub_i                   request to the hub (enable only in EXEC)
//   fp_hub_o                   hub response (combinational)
//   hub_clear_o                hub sub-unit kill
//   resp_valid_o / resp_ready_i  writeback handshake
//   resp_result_o, resp_flags_o, resp_rd_o, resp_wb_int_o, resp_timeout_o
//   flush_i                    pipeline kill
//   fflags_clr_i, fflags_o     fflags accumulator clear / value
//   busy_o                     an instruction is in flight or pending writeback
// ---------------------------------------------------------------------------
module fp_issue_ctrl
    import fp_issue_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYC = 64,
    parameter int CNT_W       = 7
)
(
    input  logic                clk,
    input  logic                rst_n,

    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic [63:0]         req_data1_i,
    input  logic [63:0]         req_data2_i,
    input  logic [63:0]         req_data3_i,
    input  fp_operation_type    req_op_i,
    input  logic [1:0]          req_fmt_i,
    input  logic [2:0]          req_rm_i,
    input  logic [4:0]          req_rd_i,
    input  logic                req_wb_int_i,

    output fp_hub_in_type       fp_hub_i,
    input  fp_hub_out_type      fp_hub_o,
    output logic                hub_clear_o,

    output logic                resp_valid_o,
    input  logic                resp_ready_i,
    output logic [63:0]         resp_result_o,
    output logic [FFLAGS_W-1:0] resp_flags_o,
    output logic [4:0]          resp_rd_o,
    output logic                resp_wb_int_o,
    output logic                resp_timeout_o,

    input  logic                flush_i,
    input  logic                fflags_clr_i,
    output logic [FFLAGS_W-1:0] fflags_o,
    output logic                busy_o
);

    localparam logic [1:0] ST_IDLE = FP_ISSUE_IDLE;
    localparam logic [1:0] ST_EXEC = FP_ISSUE_EXEC;
    localparam logic [1:0] ST_RESP = FP_ISSUE_RESP;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [1:0]        state_reg,  state_next;
    fp_issue_req_type  req_reg,    req_next;
    fp_issue_resp_type resp_reg,   resp_next;
    logic [CNT_W-1:0]  cnt_reg,    cnt_next;
    logic              flush_q_reg;
    // Holds off req_ready_o until the first clock after reset is released,
    // so every output reads 0 while reset is applied.
    logic              ready_en_reg;

    logic              in_idle;
    logic              in_exec;
    logic              in_resp;
    logic              accept;
    logic              hub_done;
    logic              handshake;

    assign in_idle = (state_reg == ST_IDLE);
    assign in_exec = (state_reg == ST_EXEC);
    assign in_resp = (state_reg == ST_RESP);

    // The clear window covers the flush cycle and the one after it, long
    // enough for multi-cycle units to drop their internal state.
    assign hub_clear_o  = flush_i | flush_q_reg;

    assign req_ready_o  = in_idle & ready_en_reg;
    assign accept       = req_valid_i & req_ready_o & ~flush_i;

    // A ready that coincides with the clear belongs to the op being killed.
    assign hub_done     = in_exec & fp_hub_o.ready & ~hub_clear_o;

    assign resp_valid_o = in_resp;
    assign handshake    = in_resp & resp_ready_i & ~flush_i;

    assign busy_o       = ~in_idle;

    // Next-state / datapath.
    always_comb begin
        state_next = state_reg;
        req_next   = req_reg;
        resp_next  = resp_reg;
        cnt_next   = cnt_reg;

        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    req_next.data1  = req_data1_i;
                    req_next.data2  = req_data2_i;
                    req_next.data3  = req_data3_i;
                    req_next.op     = req_op_i;
                    req_next.fmt    = req_fmt_i;
                    req_next.rm     = req_rm_i;
                    req_next.rd     = req_rd_i;
                    req_next.wb_int = req_wb_int_i;
                    cnt_next        = '0;
                    state_next      = ST_EXEC;
                end
            end

            ST_EXEC: begin
                if (hub_done) begin
                    resp_next.result  = fp_hub_o.result;
                    resp_next.flags   = fp_hub_o.flags;
                    resp_next.rd      = req_reg.rd;
                    resp_next.wb_int  = req_reg.wb_int;
                    resp_next.timeout = 1'b0;
                    state_next        = ST_RESP;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                    // Watchdog: the op has had its full budget of EXEC
                    // cycles; retire it with a zero result so the core
                    // cannot deadlock on a stuck unit.
                    if (cnt_reg == CNT_LAST) begin
                        resp_next.result  = '0;
                        resp_next.flags   = '0;
                        resp_next.rd      = req_reg.rd;
                        resp_next.wb_int  = req_reg.wb_int;
                        resp_next.timeout = 1'b1;
                        state_next        = ST_RESP;
                    end
                end
            end

            ST_RESP: begin
                // Returning to IDLE (rather than accepting directly) keeps
                // the hub from seeing a new enable in the retire cycle.
                if (resp_ready_i) begin
                    state_next = ST_IDLE;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase

        if (flush_i) begin
            state_next = ST_IDLE;
        end
    end

    // Hub request: only driven while executing, otherwise fully zeroed so
    // the hub never sees stale operands with enable low.
    always_comb begin
        fp_hub_i = init_fp_hub_in;
        if (in_exec) begin
            fp_hub_i.data1  = req_reg.data1;
            fp_hub_i.data2  = req_reg.data2;
            fp_hub_i.data3  = req_reg.data3;
            fp_hub_i.op     = req_reg.op;
            fp_hub_i.fmt    = req_reg.fmt;
            fp_hub_i.rm     = req_reg.rm;
            fp_hub_i.enable = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            req_reg      <= init_fp_issue_req;
            resp_reg     <= init_fp_issue_resp;
            cnt_reg      <= '0;
            flush_q_reg  <= 1'b0;
            ready_en_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            req_reg      <= req_next;
            resp_reg     <= resp_next;
            cnt_reg      <= cnt_next;
            flush_q_reg  <= flush_i;
            ready_en_reg <= 1'b1;
        end
    end

    assign resp_result_o  = resp_reg.result;
    assign resp_flags_o   = resp_reg.flags;
    assign resp_rd_o      = resp_reg.rd;
    assign resp_wb_int_o  = resp_reg.wb_int;
    assign resp_timeout_o = resp_reg.timeout;

    fp_issue_ctrl_fflags u_fflags (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (fflags_clr_i),
        .acc_en_i (handshake),
        .flags_i  (resp_reg.flags),
        .fflags_o (fflags_o)
    );

endmodule

// File: tb/tb_fp_issue_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fp_issue_ctrl
//
// Directed bench for fp_issue_ctrl. A hub stub with programmable latency
// answers requests; a timestamp-based transaction model predicts every
// output each cycle, and a few hand-computed literals pin the model.
// ---------------------------------------------------------------------------
module tb_fp_issue_ctrl;
    import fp_issue_ctrl_pkg::*;

    localparam int TIMEOUT_CYC = 64;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             req_valid_i = 1'b0;
    logic             req_ready_o;
    logic [63:0]      req_data1_i = '0;
    logic [63:0]      req_data2_i = '0;
    logic [63:0]      req_data3_i = '0;
    fp_operation_type req_op_i = '0;
    logic [1:0]       req_fmt_i = '0;
    logic [2:0]       req_rm_i = '0;
    logic [4:0]       req_rd_i = '0;
    logic             req_wb_int_i = 1'b0;
    fp_hub_in_type    fp_hub_i;
    fp_hub_out_type   fp_hub_o;
    logic             hub_clear_o;
    logic             resp_valid_o;
    logic             resp_ready_i = 1'b0;
    logic [63:0]      resp_result_o;
    logic [4:0]       resp_flags_o;
    logic [4:0]       resp_rd_o;
    logic             resp_wb_int_o;
    logic             resp_timeout_o;
    logic             flush_i = 1'b0;
    logic             fflags_clr_i = 1'b0;
    logic [4:0]       fflags_o;
    logic             busy_o;

    fp_issue_ctrl #(.TIMEOUT_CYC(TIMEOUT_CYC), .CNT_W(7)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_data1_i    (req_data1_i),
        .req_data2_i    (req_data2_i),
        .req_data3_i    (req_data3_i),
        .req_op_i       (req_op_i),
        .req_fmt_i      (req_fmt_i),
        .req_rm_i       (req_rm_i),
        .req_rd_i       (req_rd_i),
        .req_wb_int_i   (req_wb_int_i),
        .fp_hub_i       (fp_hub_i),
        .fp_hub_o       (fp_hub_o),
        .hub_clear_o    (hub_clear_o),
        .resp_valid_o   (resp_valid_o),
        .resp_ready_i   (resp_ready_i),
        .resp_result_o  (resp_result_o),
        .resp_flags_o   (resp_flags_o),
        .resp_rd_o      (resp_rd_o),
        .resp_wb_int_o  (resp_wb_int_o),
        .resp_timeout_o (resp_timeout_o),
        .flush_i        (flush_i),
        .fflags_clr_i   (fflags_clr_i),
        .fflags_o       (fflags_o),
        .busy_o         (busy_o)
    );

    always #5 clk = ~clk;

    // ---------------- hub stub ----------------
    int          stub_lat = 0;          // negative: never ready
    logic [63:0] stub_result = '0;
    logic [4:0]  stub_flags = '0;
    logic        stub_force_ready = 1'b0;
    int          stub_cnt = 0;

    always_comb begin
        fp_hub_o        = '0;
        fp_hub_o.result = stub_result;
        fp_hub_o.flags  = stub_flags;
        fp_hub_o.ready  = (fp_hub_i.enable && stub_lat >= 0 && stub_cnt == stub_lat) || stub_force_ready;
    end

    always @(posedge clk) begin
        if (!fp_hub_i.enable || hub_clear_o || fp_hub_o.ready) stub_cnt <= 0;
        else stub_cnt <= stub_cnt + 1;
    end

    // ---------------- checking helpers ----------------
    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_hub(input fp_hub_in_type act, input fp_hub_in_type exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL hub_in: got %h expected %h (t=%0t)", act, exp, $time);
        end
    endtask

    // ---------------- transaction model ----------------
    // The model tracks the op in flight by cycle stamps: accepted at cycle c,
    // it drives the hub for cycles c+1 .. resp_at-1 and responds from
    // resp_at until retired or killed.
    int               m_now = 0;
    int               m_resp_at = 0;
    bit               m_active = 0;
    bit               m_ready_ok = 0;
    bit               m_flush_q = 0;
    bit               m_in_resp, m_hs;
    logic [4:0]       m_fflags = '0;
    logic [63:0]      m_d1, m_d2, m_d3, m_res;
    fp_operation_type m_op;
    logic [1:0]       m_fmt;
    logic [2:0]       m_rm;
    logic [4:0]       m_rd, m_flg;
    logic             m_wb, m_to;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_active   = 0;
            m_fflags   = '0;
            m_ready_ok = 0;
            m_flush_q  = 0;
        end else begin
            m_in_resp = m_active && (m_now >= m_resp_at);
            m_hs      = m_in_resp && resp_ready_i && !flush_i;
            m_fflags  = (fflags_clr_i ? 5'b0 : m_fflags) | (m_hs ? m_flg : 5'b0);
            if (flush_i) begin
                if (m_active) $display("txn rd=%0d killed by flush", m_rd);
                m_active = 0;
            end else if (m_hs) begin
                $display("txn rd=%0d wb_int=%0b result=%h flags=%b timeout=%0b",
                         m_rd, m_wb, m_res, m_flg, m_to);
                m_active = 0;
            end else if (!m_active && m_ready_ok && req_valid_i) begin
                m_active = 1;
                m_d1 = req_data1_i; m_d2 = req_data2_i; m_d3 = req_data3_i;
                m_op = req_op_i; m_fmt = req_fmt_i; m_rm = req_rm_i;
                m_rd = req_rd_i; m_wb = req_wb_int_i;
                if (stub_lat < 0 || stub_lat >= TIMEOUT_CYC) begin
                    m_resp_at = m_now + 1 + TIMEOUT_CYC;
                    m_res = '0; m_flg = '0; m_to = 1;
                end else begin
                    m_resp_at = m_now + 1 + stub_lat + 1;
                    m_res = stub_result; m_flg = stub_flags; m_to = 0;
                end
            end
            m_flush_q  = flush_i;
            m_ready_ok = 1;
        end
        m_now++;
    end

    // ---------------- per-cycle compare ----------------
    bit            chk_en = 0;
    bit            c_exec, c_resp;
    fp_hub_in_type exp_hub;

    always @(negedge clk) begin
        if (chk_en) begin
            c_exec  = m_active && (m_now < m_resp_at);
            c_resp  = m_active && (m_now >= m_resp_at);
            exp_hub = '0;
            if (c_exec) begin
                exp_hub.data1 = m_d1; exp_hub.data2 = m_d2; exp_hub.data3 = m_d3;
                exp_hub.op = m_op; exp_hub.fmt = m_fmt; exp_hub.rm = m_rm;
                exp_hub.enable = 1'b1;
            end
            chk("req_ready", 64'(req_ready_o), 64'(!m_active && m_ready_ok));
            chk("busy", 64'(busy_o), 64'(m_active));
            chk("resp_valid", 64'(resp_valid_o), 64'(c_resp));
            chk("hub_clear", 64'(hub_clear_o), 64'(flush_i | m_flush_q));
            chk("fflags", 64'(fflags_o), 64'(m_fflags));
            chk_hub(fp_hub_i, exp_hub);
            if (c_resp) begin
                chk("resp_result", resp_result_o, m_res);
                chk("resp_flags", 64'(resp_flags_o), 64'(m_flg));
                chk("resp_rd", 64'(resp_rd_o), 64'(m_rd));
                chk("resp_wb_int", 64'(resp_wb_int_o), 64'(m_wb));
                chk("resp_timeout", 64'(resp_timeout_o), 64'(m_to));
            end
        end
    end

    // ---------------- activity monitors ----------------
    int en_cnt = 0;
    int clr_cnt = 0;
    always @(negedge clk) begin
        if (fp_hub_i.enable) en_cnt++;
        if (hub_clear_o) clr_cnt++;
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic issue(input fp_operation_type op, input logic [4:0] rd, input logic wb,
                         input logic [63:0] d1, input logic [63:0] d2, input logic [63:0] d3);
        req_op_i = op; req_fmt_i = 2'b01; req_rm_i = 3'b001;
        req_rd_i = rd; req_wb_int_i = wb;
        req_data1_i = d1; req_data2_i = d2; req_data3_i = d3;
        req_valid_i = 1'b1;
        tick();
        // Scramble the inputs: the hub must keep seeing the latched values.
        req_valid_i = 1'b0;
        req_data1_i = 64'hA5A5_A5A5_A5A5_A5A5;
        req_data2_i = 64'h5A5A_5A5A_5A5A_5A5A;
        req_data3_i = 64'hFFFF_0000_FFFF_0000;
        req_op_i = '1; req_rm_i = 3'b111; req_rd_i = 5'd31;
    endtask

    // Called in the first EXEC cycle; returns cycles from the accept cycle
    // to the first cycle with resp_valid_o high, at that cycle's negedge.
    task automatic wait_resp(output int lat);
        lat = 1;
        forever begin
            at_neg();
            if (resp_valid_o) break;
            lat++;
            if (lat > 200) break;
        end
    endtask

    task automatic retire();
        tick();
        resp_ready_i = 1'b1;
        tick();
        resp_ready_i = 1'b0;
    endtask

    fp_operation_type op;
    int               lat;

    initial begin
        // Reset and post-reset ready timing.
        tick(); tick();
        chk_en = 1;
        at_neg();
        chk("rst_req_ready", 64'(req_ready_o), 64'd0);
        chk("rst_resp_valid", 64'(resp_valid_o), 64'd0);
        chk("rst_fflags", 64'(fflags_o), 64'd0);
        tick(); rst_n = 1'b1;
        at_neg();
        chk("rel_req_ready_low", 64'(req_ready_o), 64'd0);
        tick(); at_neg();
        chk("rel_req_ready_high", 64'(req_ready_o), 64'd1);
        tick();

        // fsgnj.d, single-cycle.
        stub_lat = 0; stub_result = 64'h3FF0_0000_0000_0000; stub_flags = 5'b0;
        op = '0; op.fsgnj = 1'b1;
        en_cnt = 0;
        issue(op, 5'd3, 1'b0, 64'hBFF0_0000_0000_0000, 64'h3FF0_0000_0000_0000, 64'h0);
        wait_resp(lat);
        chk("fsgnj_latency", 64'(lat), 64'd2);
        chk("fsgnj_result", resp_result_o, 64'h3FF0_0000_0000_0000);
        chk("fsgnj_flags", 64'(resp_flags_o), 64'd0);
        chk("fsgnj_enable_cycles", 64'(en_cnt), 64'd1);

        // Request held high across the retire cycle: accepted only after IDLE.
        tick();
        stub_result = 64'h4000_0000_0000_0000;
        resp_ready_i = 1'b1;
        op = '0; op.fmax = 1'b1;
        req_op_i = op; req_rd_i = 5'd4; req_wb_int_i = 1'b0;
        req_data1_i = 64'h4000_0000_0000_0000; req_data2_i = 64'h3FF0_0000_0000_0000;
        req_valid_i = 1'b1;
        tick();
        resp_ready_i = 1'b0;
        at_neg();
        chk("b2b_idle_gap", 64'(busy_o), 64'd0);
        tick();
        req_valid_i = 1'b0;
        wait_resp(lat);
        chk("b2b_latency", 64'(lat), 64'd2);
        retire();

        // fdiv.d, latency 12, response held under back-pressure.
        stub_lat = 12; stub_result = 64'h3FE0_0000_0000_0000; stub_flags = 5'b00001;
        op = '0; op.fdiv = 1'b1;
        en_cnt = 0;
        issue(op, 5'd7, 1'b0, 64'h3FF0_0000_0000_0000, 64'h4000_0000_0000_0000, 64'h0);
        wait_resp(lat);
        chk("fdiv_latency", 64'(lat), 64'd14);
        chk("fdiv_enable_cycles", 64'(en_cnt), 64'd13);
        chk("fdiv_fflags_before", 64'(fflags_o), 64'd0);
        // A stray hub ready with a different result must not be recaptured.
        stub_force_ready = 1'b1; stub_result = 64'hDEAD_BEEF_DEAD_BEEF;
        repeat (5) tick();
        at_neg();
        chk("fdiv_held_valid", 64'(resp_valid_o), 64'd1);
        chk("fdiv_held_result", resp_result_o, 64'h3FE0_0000_0000_0000);
        stub_force_ready = 1'b0;
        retire();
        at_neg();
        chk("fdiv_fflags_after", 64'(fflags_o), 64'b00001);

        // Watchdog: stub never ready.
        tick();
        stub_lat = -1; stub_result = 64'h1234_5678_9ABC_DEF0; stub_flags = 5'b11111;
        op = '0; op.fsqrt = 1'b1;
        en_cnt = 0;
        issue(op, 5'd9, 1'b0, 64'h4010_0000_0000_0000, 64'h0, 64'h0);
        wait_resp(lat);
        chk("timeout_latency", 64'(lat), 64'd65);
        chk("timeout_enable_cycles", 64'(en_cnt), 64'd64);
        chk("timeout_flag", 64'(resp_timeout_o), 64'd1);
        chk("timeout_result", resp_result_o, 64'd0);
        retire();

        // Flush at EXEC cycle 3 of a latency-10 op.
        stub_lat = 10; stub_result = 64'h4008_0000_0000_0000; stub_flags = 5'b11111;
        op = '0; op.fmadd = 1'b1;
        issue(op, 5'd12, 1'b0, 64'h3FF0_0000_0000_0000, 64'h4000_0000_0000_0000,
              64'h3FF0_0000_0000_0000);
        clr_cnt = 0;
        tick(); tick();
        flush_i = 1'b1;
        at_neg();
        chk("flush_clear_now", 64'(hub_clear_o), 64'd1);
        tick();
        flush_i = 1'b0;
        at_neg();
        chk("flush_idle_next", 64'(busy_o), 64'd0);
        chk("flush_clear_q", 64'(hub_clear_o), 64'd1);
        tick();
        stub_force_ready = 1'b1;
        repeat (3) tick();
        at_neg();
        chk("flush_late_ready_ignored", 64'(resp_valid_o), 64'd0);
        stub_force_ready = 1'b0;
        chk("flush_clear_cycles", 64'(clr_cnt), 64'd2);
        chk("flush_fflags_kept", 64'(fflags_o), 64'b00001);

        // fflags: explicit clear, then clear coinciding with a retire.
        tick();
        fflags_clr_i = 1'b1;
        tick();
        fflags_clr_i = 1'b0;
        at_neg();
        chk("fflags_cleared", 64'(fflags_o), 64'd0);
        tick();
        stub_lat = 2; stub_result = 64'h0000_0000_0000_0001; stub_flags = 5'b10000;
        op = '0; op.fadd = 1'b1;
        issue(op, 5'd14, 1'b0, 64'h1, 64'h2, 64'h0);
        wait_resp(lat);
        chk("fadd_latency", 64'(lat), 64'd4);
        retire();
        at_neg();
        chk("fflags_nv", 64'(fflags_o), 64'b10000);
        tick();
        stub_lat = 0; stub_result = 64'h0000_0000_0000_0001; stub_flags = 5'b00100;
        op = '0; op.fcmp = 1'b1;
        issue(op, 5'd15, 1'b1, 64'h7FF0_0000_0000_0000, 64'h0, 64'h0);
        wait_resp(lat);
        tick();
        resp_ready_i = 1'b1; fflags_clr_i = 1'b1;
        tick();
        resp_ready_i = 1'b0; fflags_clr_i = 1'b0;
        at_neg();
        chk("fflags_clr_with_retire", 64'(fflags_o), 64'b00100);

        // Reset while a response is pending.
        tick();
        stub_lat = 0; stub_result = 64'h0000_0000_0000_0200; stub_flags = 5'b00010;
        op = '0; op.fclass = 1'b1;
        issue(op, 5'd21, 1'b1, 64'h3FF0_0000_0000_0000, 64'h0, 64'h0);
        wait_resp(lat);
        tick();
        rst_n = 1'b0;
        tick();
        at_neg();
        chk("rst2_resp_valid", 64'(resp_valid_o), 64'd0);
        chk("rst2_req_ready", 64'(req_ready_o), 64'd0);
        chk("rst2_busy", 64'(busy_o), 64'd0);
        chk("rst2_fflags", 64'(fflags_o), 64'd0);
        chk("rst2_result", resp_result_o, 64'd0);
        chk("rst2_flags", 64'(resp_flags_o), 64'd0);
        chk("rst2_rd", 64'(resp_rd_o), 64'd0);
        chk("rst2_wb_int", 64'(resp_wb_int_o), 64'd0);
        chk("rst2_timeout", 64'(resp_timeout_o), 64'd0);
        chk("rst2_enable", 64'(fp_hub_i.enable), 64'd0);
        tick();
        rst_n = 1'b1;
        at_neg();
        chk("rst2_ready_low", 64'(req_ready_o), 64'd0);
        tick();
        at_neg();
        chk("rst2_ready_high", 64'(req_ready_o), 64'd1);

        // One more op to confirm normal operation after reset.
        tick();
        stub_lat = 3; stub_result = 64'hC000_0000_0000_0000; stub_flags = 5'b00001;
        op = '0; op.fmul = 1'b1;
        issue(op, 5'd2, 1'b0, 64'h4000_0000_0000_0000, 64'hBFF0_0000_0000_0000, 64'h0);
        wait_resp(lat);
        chk("fmul_latency", 64'(lat), 64'd5);
        retire();
        at_neg();
        chk("fmul_fflags", 64'(fflags_o), 64'b00001);

        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_time_limit: simulation did not complete");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/fp_issue_ctrl.md
Name: fp_issue_ctrl

Overview:
Issue/writeback controller on the requester side of fp_hub. It accepts one FP instruction at a time from the core execute stage and drives fp_hub_in_type and the hub clear input. It holds the operands stable while multi-cycle units (fma, fdiv, cvt) run, captures the hub's combinational result on the first ready cycle, and returns it to writeback through a valid/ready response handshake. It also keeps the architectural fflags accumulator.

Parameters:
TIMEOUT_CYC, 64, max EXEC cycles before a forced abort (watchdog); must be >= worst fdiv/fsqrt latency + 2
CNT_W, 7, watchdog counter width; must satisfy 2^CNT_W > TIMEOUT_CYC

Ports:
clk  in  1  core clock
rst_n  in  1  reset; synchronous, active-low
req_valid_i  in  1  instruction request valid
req_ready_o  out  1  controller can accept
req_data1_i/req_data2_i/req_data3_i  in  64 each  source operands (raw, NaN-boxed)
req_op_i  in  fp_operation_type  decoded op one-hot struct
req_fmt_i  in  2  format
req_rm_i  in  3  resolved rounding mode
req_rd_i  in  5  destination register index
req_wb_int_i  in  1  1 = integer regfile destination (fcmp/fclass/fmv_f2i/fcvt_f2i)
fp_hub_i  out  fp_hub_in_type  hub request
fp_hub_o  in  fp_hub_out_type  hub response: result/flags/ready, combinational
hub_clear_o  out  1  to hub clear input
resp_valid_o  out  1  result available
resp_ready_i  in  1  writeback accepts
resp_result_o  out  64  captured result
resp_flags_o  out  5  captured exception flags
resp_rd_o  out  5  destination index
resp_wb_int_o  out  1  destination regfile select
resp_timeout_o  out  1  result produced by watchdog abort
flush_i  in  1  pipeline flush / kill
fflags_clr_i  in  1  CSR write clears accumulator
fflags_o  out  5  accumulated fflags
busy_o  out  1  state != IDLE

Behaviour:
- States: IDLE, EXEC, RESP. Reset (rst_n=0 at posedge) -> IDLE. All response regs, fflags_o, watchdog counter and flush_q clear to 0. fp_hub_i.enable is 0 in IDLE and RESP.
- IDLE: req_ready_o=1. On req_valid_i & req_ready_o: latch data1..3, op, fmt, rm, rd, wb_int; counter<=0; go EXEC.
- EXEC: req_ready_o=0. fp_hub_i.enable=1 with latched fields; otherwise enable=0 and all fields 0.
  - On fp_hub_o.ready=1 & !hub_clear_o: capture result/flags into response regs, resp_timeout<=0, go RESP. enable drops the next cycle, so the hub sees exactly one enabled cycle after ready.
  - Else counter++. When counter==TIMEOUT_CYC-1 without ready: capture result=0, flags=0, resp_timeout<=1, go RESP.
- RESP: resp_valid_o=1, outputs stable until handshake. On resp_ready_i go IDLE. No new request is accepted in the same cycle, so issue-to-issue is at least 3 cycles.
- Latency for single-cycle hub ops (fsgnj, fcmp, fmax, fclass, fmv): accept at cycle T, EXEC at T+1, resp_valid_o at T+2. Multi-cycle ops take hub latency L: resp_valid_o at T+1+L+1.
- Flush: flush_i overrides everything. Next state is IDLE from any state. The response is discarded and the accept is suppressed even if req_valid_i is high. flush_q<=flush_i. hub_clear_o = flush_i | flush_q, a 2-cycle window that kills sub-unit state. fflags are not updated for the killed op.
- fflags: fflags_o_next = (fflags_clr_i ? 0 : fflags_o) | (resp_valid_o & resp_ready_i & !flush_i ? resp_flags_o : 0). When clear and handshake happen in the same cycle, the new flags survive.
- hub ready outside EXEC is ignored.

Decomposition:
- fp_types package gains:
  - fp_issue_state_type enum (IDLE/EXEC/RESP)
  - fp_issue_req_type struct (data1..3, op, fmt, rm, rd, wb_int)
  - fp_issue_resp_type struct (result, flags, rd, wb_int, timeout)
  - init_fp_issue_req/init_fp_issue_resp constants
- Single module. A separate fp_fflags_acc sub-module is optional but not required.

Test Plan:
- Bench uses a behavioural hub stub with per-op programmable latency.
- fsgnj.d, data1=0xBFF0000000000000, data2=0x3FF0000000000000, stub latency 0 with result 0x3FF0000000000000 -> resp_valid_o exactly 2 cycles after accept, flags 0, enable high exactly 1 cycle.
- fdiv.d, stub latency 12 returning 0x3FE0000000000000 flags 5'b00001 -> operands stable for all 13 EXEC cycles; response held under resp_ready_i=0 for 5 cycles; fflags_o=5'b00001 only after handshake.
- Stub never asserts ready, TIMEOUT_CYC=64 -> resp_timeout_o=1, result 0, after exactly 64 EXEC cycles.
- flush_i pulsed at EXEC cycle 3 of a latency-10 op -> hub_clear_o high 2 cycles; IDLE next cycle; no response; a late stub ready is ignored; fflags_o unchanged.
- fflags_o=5'b10000, then fflags_clr_i in the same cycle as a handshake carrying 5'b00100 -> fflags_o=5'b00100.
- rst_n=0 during RESP -> all outputs 0 next cycle; req_ready_o=1 one cycle after rst_n rises.
